pe_acc: RTL
===========

Name: pe_acc

Overview:
Accumulation stage directly downstream of pe_mux inside the PE. Consumes the stream of signed W-bit operands selected by the mux, sums one group of beats (delimited by in_last) into a wide accumulator, then presents one saturated OUT_W-bit result per group on a valid/ready output. This stage is the PE's reduction point before results leave for the array output path.

Parameters:
W, 24, width of signed input operand (matches pe_mux W)
ACC_W, 32, internal accumulator width, signed, must be > W
OUT_W, 24, result width after saturation, OUT_W <= ACC_W
CNT_W, 16, width of the beat counter reported with each result

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  operand beat valid
in_ready  out  1  stage can accept a beat this cycle
in_data  in  W  signed operand from pe_mux y
in_last  in  1  marks the final beat of a group, qualified by in_valid
out_valid  out  1  result available
out_ready  in  1  downstream accepts the result
out_data  out  OUT_W  signed saturated group sum
out_sat  out  1  saturation occurred anywhere in this group
out_cnt  out  CNT_W  beats in this group, saturating at 2^CNT_W-1

Behaviour:
- Reset: one clock and one reset. Reset is synchronous and active-low on rst_n, sampled on the rising edge of clk.
- Reset values: state=ACC, acc=0, first=1, sat_flag=0, cnt=0, out_valid=0, out_data=0, out_sat=0, out_cnt=0. in_ready is high in the first cycle after reset.
- A reset in mid-group or in HOLD discards the partial sum and any pending result. No output is produced for that group.
- A beat fires when in_valid & in_ready. A result fires when out_valid & out_ready.
- FSM, two states:
  - ACC: in_ready=1, out_valid=0.
  - HOLD: out_valid=1 and in_ready=out_ready.
- Beat fire updates:
  - Base: base = first ? 0 : acc.
  - Sum: acc <= sat_ACC(base + sext(in_data)). The add is computed at ACC_W+1 bits, then clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. If clamped, sat_flag is set.
  - Count: cnt <= first ? 1 : min(cnt+1, max).
  - first <= in_last.
- Beat with in_last:
  - out_data <= sat_OUT(new acc). The new acc is clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - out_sat <= sat_flag of this group, including this beat's add clamp and the final narrowing clamp.
  - out_cnt <= new cnt.
  - sat_flag <= 0. Next state is HOLD.
  - Latency: out_valid rises the cycle after the last beat fires.
- HOLD with out_ready=0: out_data, out_sat and out_cnt stay stable. in_ready=0 (backpressure).
- HOLD with out_ready=1 and no beat fire: the result fires. Next state is ACC, out_valid=0.
- HOLD with the result and a beat firing in the same cycle: the beat is the first beat of the next group (first=1 is guaranteed).
  - If that beat has in_last, the new result loads and the state stays HOLD with out_valid=1.
  - Otherwise the next state is ACC.
- in_last on a single-beat group: out_data = sat_OUT(sext(in_data)) and out_cnt=1.
- in_valid=0 in ACC: all state holds, with no timeout.
- Outputs are registered, with no combinational path from in_data to out_data. in_ready depends combinationally only on state and out_ready.

Test Plan:
- Sum: after reset, beats 100, -50, 7(last) with out_ready=1 -> one cycle later out_valid=1, out_data=57, out_cnt=3, out_sat=0. The result drops after 1 cycle.
- Positive saturation: beats 8388607, 8388607(last) -> out_data=8388607, out_sat=1, out_cnt=2. A following group of 5(last) -> out_data=5, out_sat=0.
- Negative saturation: beats -8388608, -8388608, -1(last) -> out_data=-8388608, out_sat=1.
- Backpressure: group -12345(last) with out_ready=0 for 5 cycles. During those cycles out_data=-12345 is stable and in_ready=0. A beat offered during that window is not accepted. Raising out_ready -> the result fires once.
- Back-to-back in HOLD: out_ready=1 held, single-beat groups 1, 2, 3 on consecutive cycles -> out_valid is continuously high and out_data=1, 2, 3 on consecutive cycles, each with out_cnt=1.
- Reset mid-group: beats 40, 60, then rst_n=0 for 1 cycle, then beat 9(last) -> out_data=9, out_cnt=1. No result for the aborted group.

Source files
------------

// File: rtl/pe_acc.sv
//==============================================================================
// pe_acc : group accumulator that emits one saturated sum per in_last group
// Rev 1.0
//==============================================================================
`default_nettype none

module pe_acc #(
    parameter int W     = 24,
    parameter int ACC_W = 32,
    parameter int OUT_W = 24,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [W-1:0]     in_data,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_sat,
    output logic [CNT_W-1:0]        out_cnt
);

    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               first_q, first_d;
    logic               sat_flag_q, sat_flag_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OUT_W-1:0]   out_data_q, out_data_d;
    logic               out_sat_q, out_sat_d;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;

    logic               beat_fire;
    logic               res_fire;
    logic [ACC_W-1:0]   base;
    logic [ACC_W:0]     sum_wide;
    logic               add_clamp;
    logic [ACC_W-1:0]   acc_new;
    logic [ACC_W-OUT_W:0] acc_top;
    logic               narrow_clamp;
    logic [OUT_W-1:0]   out_new;
    logic [CNT_W-1:0]   cnt_new;

    assign in_ready  = (state_q == ST_ACC) | out_ready;
    assign out_valid = (state_q == ST_HOLD);
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign out_cnt   = out_cnt_q;

    assign beat_fire = in_valid & in_ready;
    assign res_fire  = out_valid & out_ready;

    // One extra bit of headroom makes the overflow test a simple sign-bit compare.
    assign base      = first_q ? '0 : acc_q;
    assign sum_wide  = {base[ACC_W-1], base} + {{(ACC_W+1-W){in_data[W-1]}}, in_data};
    assign add_clamp = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    assign acc_new   = add_clamp ? (sum_wide[ACC_W] ? ACC_MIN : ACC_MAX)
                                 : sum_wide[ACC_W-1:0];

    // The value fits OUT_W only if every bit from OUT_W-1 upward matches the sign.
    assign acc_top      = acc_new[ACC_W-1:OUT_W-1];
    assign narrow_clamp = ~((&acc_top) | ~(|acc_top));
    assign out_new      = narrow_clamp ? (acc_new[ACC_W-1] ? OUT_MIN : OUT_MAX)
                                       : acc_new[OUT_W-1:0];

    assign cnt_new = first_q ? CNT_ONE : ((&cnt_q) ? cnt_q : cnt_q + CNT_ONE);

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        first_d    = first_q;
        sat_flag_d = sat_flag_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
        out_sat_d  = out_sat_q;
        out_cnt_d  = out_cnt_q;

        if (res_fire) begin
            state_d = ST_ACC;
        end

        if (beat_fire) begin
            acc_d      = acc_new;
            cnt_d      = cnt_new;
            first_d    = in_last;
            sat_flag_d = sat_flag_q | add_clamp;
            if (in_last) begin
                out_data_d = out_new;
                out_sat_d  = sat_flag_q | add_clamp | narrow_clamp;
                out_cnt_d  = cnt_new;
                sat_flag_d = 1'b0;
                state_d    = ST_HOLD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_ACC;
            acc_q      <= '0;
            first_q    <= 1'b1;
            sat_flag_q <= 1'b0;
            cnt_q      <= '0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
            out_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            first_q    <= first_d;
            sat_flag_q <= sat_flag_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
            out_sat_q  <= out_sat_d;
            out_cnt_q  <= out_cnt_d;
        end
    end

endmodule

`default_nettype wire
